decodifica_hamming: RTL and testbench

Pipelined Hamming(15,11) single-error-correcting decoder; the receive-side counterpart of the team's combinational Hamming(15,11) encoder. It accepts 15-bit codewords over a valid/ready handshake and computes the 4-bit syndrome. It corrects any single flipped bit, extracts the 11 data bits, and reports per-word error flags plus a saturating corrected-error counter. It sits between the channel/deserializer and the data consumer.

---
 rtl/hamming_pkg.sv | 37 +++
 rtl/sindrome_hamming.sv | 11 +
 rtl/decodifica_hamming.sv | 129 ++++++++++++
 tb/tb_decodifica_hamming.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - Hamming(15,11) constants, position map and syndrome helper
// Shared by the decoder and the encoder bench.
package hamming_pkg;

  localparam int HAM_N = 15;
  localparam int HAM_K = 11;
  localparam int HAM_R = 4;

  // Codeword bit index holding data bit j (positions 3,5,6,7,9..15).
  localparam logic [HAM_K-1:0][3:0] DATA_IDX = {
    4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8, 4'd6, 4'd5, 4'd4, 4'd2
  };

  // XOR of the positions of all set bits; equals the even-parity syndrome.
  function automatic logic [HAM_R-1:0] calc_sindrome(input logic [HAM_N-1:0] cw);
    logic [HAM_R-1:0] s;
    s = '0;
    for (int p = 1; p <= HAM_N; p++) begin
      if (cw[p-1]) s = s ^ p[HAM_R-1:0];
    end
    return s;
  endfunction

  function automatic logic [HAM_K-1:0] extrai_dados(input logic [HAM_N-1:0] cw);
    logic [HAM_K-1:0] d;
    d = '0;
    for (int j = 0; j < HAM_K; j++) begin
      d[j] = cw[DATA_IDX[j]];
    end
    return d;
  endfunction

  function automatic logic eh_paridade(input logic [HAM_R-1:0] s);
    return (s == 4'd1) || (s == 4'd2) || (s == 4'd4) || (s == 4'd8);
  endfunction

endpackage

// File: rtl/sindrome_hamming.sv
// rtl/sindrome_hamming.sv - combinational 15-bit codeword to 4-bit syndrome
module sindrome_hamming
  import hamming_pkg::*;
(
  input  logic [HAM_N-1:0] codeword,
  output logic [HAM_R-1:0] sindrome
);

  assign sindrome = calc_sindrome(codeword);

endmodule

// File: rtl/decodifica_hamming.sv
// rtl/decodifica_hamming.sv - two-stage Hamming(15,11) SEC decoder with valid/ready
module decodifica_hamming
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [14:0]      entrada,
  input  logic             entrada_valida,
  output logic             entrada_pronta,
  output logic [10:0]      saida,
  output logic             saida_valida,
  input  logic             saida_pronta,
  output logic [3:0]       sindrome,
  output logic             erro_corrigido,
  output logic             erro_em_paridade,
  input  logic             limpa_contador,
  output logic [CNT_W-1:0] cnt_corrigidos
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [HAM_R-1:0] sind_entrada;

  logic             s1_valid_q, s1_valid_d;
  logic [HAM_N-1:0] s1_cw_q, s1_cw_d;
  logic [HAM_R-1:0] s1_syn_q, s1_syn_d;

  logic             s2_valid_q, s2_valid_d;
  logic [HAM_K-1:0] s2_data_q, s2_data_d;
  logic [HAM_R-1:0] s2_syn_q, s2_syn_d;
  logic             s2_err_q, s2_err_d;
  logic             s2_par_q, s2_par_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_load, s2_load, out_xfer;
  logic [HAM_N-1:0] flip_mask, cw_corr;

  sindrome_hamming u_sindrome (
    .codeword (entrada),
    .sindrome (sind_entrada)
  );

  // Ready ripples back combinationally so a full pipeline never bubbles.
  assign s2_load  = !s2_valid_q || saida_pronta;
  assign s1_load  = !s1_valid_q || s2_load;
  assign out_xfer = s2_valid_q && saida_pronta;

  always_comb begin
    flip_mask = '0;
    if (s1_syn_q != '0) flip_mask = HAM_N'(1) << (s1_syn_q - 4'd1);
    cw_corr = s1_cw_q ^ flip_mask;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cw_d    = s1_cw_q;
    s1_syn_d   = s1_syn_q;
    if (s1_load) begin
      s1_valid_d = entrada_valida;
      if (entrada_valida) begin
        s1_cw_d  = entrada;
        s1_syn_d = sind_entrada;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_syn_d   = s2_syn_q;
    s2_err_d   = s2_err_q;
    s2_par_d   = s2_par_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = extrai_dados(cw_corr);
        s2_syn_d  = s1_syn_q;
        s2_err_d  = (s1_syn_q != '0);
        s2_par_d  = eh_paridade(s1_syn_q);
      end
    end
  end

  // Clear has priority over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (limpa_contador) begin
      cnt_d = '0;
    end else if (out_xfer && s2_err_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_cw_q    <= '0;
      s1_syn_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_syn_q   <= '0;
      s2_err_q   <= 1'b0;
      s2_par_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_cw_q    <= s1_cw_d;
      s1_syn_q   <= s1_syn_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_syn_q   <= s2_syn_d;
      s2_err_q   <= s2_err_d;
      s2_par_q   <= s2_par_d;
      cnt_q      <= cnt_d;
    end
  end

  assign entrada_pronta   = s1_load;
  assign saida            = s2_data_q;
  assign saida_valida     = s2_valid_q;
  assign sindrome         = s2_syn_q;
  assign erro_corrigido   = s2_err_q;
  assign erro_em_paridade = s2_par_q;
  assign cnt_corrigidos   = cnt_q;

endmodule

// File: tb/tb_decodifica_hamming.sv
// tb/tb_decodifica_hamming.sv - directed and table-driven bench for decodifica_hamming
module tb_decodifica_hamming;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] entrada;
  logic        entrada_valida;
  logic        entrada_pronta, entrada_pronta_b;
  logic [10:0] saida, saida_b;
  logic        saida_valida, saida_valida_b;
  logic        saida_pronta;
  logic [3:0]  sindrome, sindrome_b;
  logic        erro_corrigido, erro_corrigido_b;
  logic        erro_em_paridade, erro_em_paridade_b;
  logic        limpa_contador;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [10:0] cur_data;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  decodifica_hamming #(.CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .entrada(entrada), .entrada_valida(entrada_valida),
    .entrada_pronta(entrada_pronta), .saida(saida), .saida_valida(saida_valida),
    .saida_pronta(saida_pronta), .sindrome(sindrome), .erro_corrigido(erro_corrigido),
    .erro_em_paridade(erro_em_paridade), .limpa_contador(limpa_contador),
    .cnt_corrigidos(cnt_a)
  );

  decodifica_hamming #(.CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .entrada(entrada), .entrada_valida(entrada_valida),
    .entrada_pronta(entrada_pronta_b), .saida(saida_b), .saida_valida(saida_valida_b),
    .saida_pronta(saida_pronta), .sindrome(sindrome_b), .erro_corrigido(erro_corrigido_b),
    .erro_em_paridade(erro_em_paridade_b), .limpa_contador(limpa_contador),
    .cnt_corrigidos(cnt_b)
  );

  typedef struct {
    logic [14:0] cw;
    logic [10:0] data;
    logic [3:0]  syn;
    logic        err;
    logic        par;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [14:0] encode(input logic [10:0] d);
    logic [14:0] cw;
    cw = '0;
    cw[2] = d[0];
    cw[4] = d[1];
    cw[5] = d[2];
    cw[6] = d[3];
    cw[14:8] = d[10:4];
    cw[0] = ^(cw & 15'h5555);
    cw[1] = ^(cw & 15'h6666);
    cw[3] = ^(cw & 15'h7878);
    cw[7] = ^(cw & 15'h7F80);
    return cw;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Call just after a negedge (plus #1); scores the coming edge's transfers.
  task automatic step(output bit acc);
    logic [10:0] e;
    acc = entrada_valida && entrada_pronta;
    if (saida_valida && saida_pronta) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_output");
      end else begin
        e = exp_q.pop_front();
        chk("stream_data", {21'd0, saida}, {21'd0, e});
        n_out++;
      end
    end
    if (acc) exp_q.push_back(cur_data);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [14:0] cw, input logic [10:0] d);
    bit acc;
    acc = 1'b0;
    entrada = cw;
    cur_data = d;
    entrada_valida = 1'b1;
    for (int t = 0; t < 4 && !acc; t++) begin
      #1;
      step(acc);
    end
    if (!acc) fail_now("accept_timeout");
    entrada_valida = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    entrada_valida = 1'b0;
    saida_pronta = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) begin
      #1;
      step(acc);
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin
    bit acc;
    int exp_cnt;
    int idx;
    logic [14:0] bp_cw[6];
    logic [10:0] bp_d[6];

    vecs[0] = '{15'h0000, 11'h000, 4'd0,  1'b0, 1'b0};
    vecs[1] = '{15'h0007, 11'h001, 4'd0,  1'b0, 1'b0};
    vecs[2] = '{15'h7FFF, 11'h7FF, 4'd0,  1'b0, 1'b0};
    vecs[3] = '{15'h0017, 11'h001, 4'd5,  1'b1, 1'b0};
    vecs[4] = '{15'h0087, 11'h001, 4'd8,  1'b1, 1'b1};
    vecs[5] = '{15'h7FFE, 11'h7FF, 4'd1,  1'b1, 1'b1};
    vecs[6] = '{15'h3FFF, 11'h7FF, 4'd15, 1'b1, 1'b0};
    vecs[7] = '{15'h7FFB, 11'h7FF, 4'd3,  1'b1, 1'b0};

    rst_n = 1'b0;
    entrada = '0;
    entrada_valida = 1'b0;
    saida_pronta = 1'b0;
    limpa_contador = 1'b0;
    cur_data = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_saida_valida", {31'd0, saida_valida}, 32'd0);
    chk("rst_entrada_pronta", {31'd0, entrada_pronta}, 32'd1);
    chk("rst_saida", {21'd0, saida}, 32'd0);
    chk("rst_sindrome", {28'd0, sindrome}, 32'd0);
    chk("rst_flags", {30'd0, erro_corrigido, erro_em_paridade}, 32'd0);
    chk("rst_cnt", {16'd0, cnt_a}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single words, checking latency and every output field.
    exp_cnt = 0;
    foreach (vecs[i]) begin
      entrada = vecs[i].cw;
      entrada_valida = 1'b1;
      saida_pronta = 1'b1;
      #1;
      chk("tbl_in_ready", {31'd0, entrada_pronta}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      entrada_valida = 1'b0;
      #1;
      chk("tbl_not_yet_valid", {31'd0, saida_valida}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("tbl_valid", {31'd0, saida_valida}, 32'd1);
      chk("tbl_saida", {21'd0, saida}, {21'd0, vecs[i].data});
      chk("tbl_sindrome", {28'd0, sindrome}, {28'd0, vecs[i].syn});
      chk("tbl_erro", {31'd0, erro_corrigido}, {31'd0, vecs[i].err});
      chk("tbl_paridade", {31'd0, erro_em_paridade}, {31'd0, vecs[i].par});
      if (vecs[i].err) exp_cnt++;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("tbl_cnt", {16'd0, cnt_a}, exp_cnt);
      chk("tbl_drained", {31'd0, saida_valida}, 32'd0);
    end

    limpa_contador = 1'b1;
    #1;
    step(acc);
    limpa_contador = 1'b0;
    #1;
    chk("clear_cnt", {16'd0, cnt_a}, 32'd0);

    // Exhaustive 0-or-1 bit flip sweep at full throughput.
    n_out = 0;
    saida_pronta = 1'b1;
    for (int d = 0; d < 2048; d++) begin
      for (int f = 0; f < 16; f++) begin
        logic [14:0] m;
        m = (f == 0) ? 15'd0 : (15'd1 << (f - 1));
        send_word(encode(d[10:0]) ^ m, d[10:0]);
      end
    end
    drain();
    chk("sweep_outputs", n_out, 32768);
    chk("sweep_cnt", {16'd0, cnt_a}, 30720);
    chk("sweep_cnt_sat4", {28'd0, cnt_b}, 15);

    // Backpressure: 6 words, saida_pronta low for the first 5 cycles.
    for (int i = 0; i < 6; i++) begin
      bp_d[i] = 11'h123 + 11'(i * 97);
      bp_cw[i] = encode(bp_d[i]) ^ ((i % 2 == 0) ? (15'd1 << 4) : 15'd0);
    end
    n_out = 0;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      saida_pronta = (c >= 5);
      if (idx < 6) begin
        entrada = bp_cw[idx];
        cur_data = bp_d[idx];
        entrada_valida = 1'b1;
      end else begin
        entrada_valida = 1'b0;
      end
      #1;
      if (c >= 2 && c <= 4) begin
        chk("bp_in_ready_low", {31'd0, entrada_pronta}, 32'd0);
        chk("bp_hold_valid", {31'd0, saida_valida}, 32'd1);
        chk("bp_hold_data", {21'd0, saida}, {21'd0, bp_d[0]});
        chk("bp_hold_syn", {28'd0, sindrome}, 32'd5);
        chk("bp_hold_err", {31'd0, erro_corrigido}, 32'd1);
      end
      if (c == 5) chk("bp_resume_ready", {31'd0, entrada_pronta}, 32'd1);
      step(acc);
      if (acc) idx++;
    end
    chk("bp_outputs", n_out, 6);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Saturation: 20 corrected words into a 4-bit counter.
    limpa_contador = 1'b1;
    entrada_valida = 1'b0;
    #1;
    step(acc);
    limpa_contador = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send_word(encode(11'(i * 37)) ^ (15'd1 << (i % 15)), 11'(i * 37));
    end
    drain();
    #1;
    chk("sat_cnt16", {16'd0, cnt_a}, 20);
    chk("sat_cnt4", {28'd0, cnt_b}, 15);

    // Clear on the same edge as a corrected transfer.
    send_word(15'h0017, 11'h001);
    for (int t = 0; t < 5 && !saida_valida; t++) begin
      #1;
      step(acc);
    end
    if (!saida_valida) fail_now("clear_wait_timeout");
    limpa_contador = 1'b1;
    #1;
    step(acc);
    limpa_contador = 1'b0;
    #1;
    chk("clear_wins_a", {16'd0, cnt_a}, 32'd0);
    chk("clear_wins_b", {28'd0, cnt_b}, 32'd0);

    // Reset with two words in flight.
    send_word(15'h0017, 11'h001);
    drain();
    #1;
    chk("pre_rst_cnt", {16'd0, cnt_a}, 32'd1);
    entrada = 15'h0017;
    cur_data = 11'h001;
    entrada_valida = 1'b1;
    #1;
    step(acc);
    entrada = 15'h0087;
    #1;
    step(acc);
    entrada_valida = 1'b0;
    #1;
    chk("inflight_valid", {31'd0, saida_valida}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, saida_valida}, 32'd0);
    chk("rst_mid_cnt", {16'd0, cnt_a}, 32'd0);
    chk("rst_mid_ready", {31'd0, entrada_pronta}, 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk("post_rst_no_output", {31'd0, saida_valida}, 32'd0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
